// File: rtl/keypad_entry.sv
// -----------------------------------------------------------------------------
// keypad_entry
//
// Scans a 4x4 active-low matrix keypad, debounces whole-keypad scan results and
// decodes one hex digit per accepted press. Accepted digits are stored first
// into four username registers, then into four password registers. inputCount
// reports how many digits are stored (0..8, saturating). The unlocker reads
// the digit registers and uses resetCount to clear them.
//
// Parameters
//   SCAN_DIV        clk cycles each column is driven (must be >= 4 because of
//                   the 2-flop row synchronizer)
//   DEBOUNCE_SCANS  consecutive identical full scans needed to accept or
//                   release a key (must be >= 2)
//
// Ports
//   clk                 system clock
//   rst                 asynchronous reset, active-high
//   row[3:0]            keypad rows, active-low (external pull-ups)
//   col[3:0]            keypad column drive, active-low, one-hot-low
//   resetCount          level; clears inputCount and all digit registers
//   userNameInput0..3   username digits, index 0 = first key entered
//   passwordInput0..3   password digits, index 0 = fifth key entered
//   inputCount[3:0]     number of digits stored, 0..8
//   key_valid           one-cycle pulse when a key press is accepted
//   key_code[3:0]       code of the last accepted key
// -----------------------------------------------------------------------------
module keypad_entry #(
   parameter int SCAN_DIV       = 25000,
   parameter int DEBOUNCE_SCANS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   input  logic       resetCount,
   output logic [3:0] userNameInput0,
   output logic [3:0] userNameInput1,
   output logic [3:0] userNameInput2,
   output logic [3:0] userNameInput3,
   output logic [3:0] passwordInput0,
   output logic [3:0] passwordInput1,
   output logic [3:0] passwordInput2,
   output logic [3:0] passwordInput3,
   output logic [3:0] inputCount,
   output logic       key_valid,
   output logic [3:0] key_code
);

   localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DCNT_W = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [CNT_W-1:0]  SCAN_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_SCANS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS,
      ST_HELD,
      ST_RELEASE
   } state_t;

   typedef enum logic [1:0] {
      RES_NONE,
      RES_KEY,
      RES_MULTI
   } result_t;

   // Keypad legend, indexed by physical row and column.
   function automatic logic [3:0] decode_key(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
         4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
         4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
         4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
      endcase
      return k;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [3:0]        row_s1_q, row_s2_q;
   logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
   logic [1:0]        col_idx_q,  col_idx_d;
   logic [3:0]        col_q,      col_d;
   logic [1:0]        acc_hits_q, acc_hits_d;   // 0, 1, or 2 (= more than one)
   logic [3:0]        acc_code_q, acc_code_d;
   state_t            state_q,    state_d;
   logic [3:0]        cand_q,     cand_d;
   logic [DCNT_W-1:0] dcnt_q,     dcnt_d;
   logic              key_valid_q, key_valid_d;
   logic [3:0]        key_code_q,  key_code_d;
   logic [3:0]        count_q,     count_d;
   logic [7:0][3:0]   digit_q,     digit_d;     // 0..3 username, 4..7 password

   // ---------------------------------------------------------------------------
   // Scan datapath
   // ---------------------------------------------------------------------------
   logic       sample;
   logic       scan_end;
   logic [2:0] col_hits;
   logic [3:0] col_code;
   logic [2:0] hit_sum;
   logic [1:0] merged_hits;
   logic [3:0] merged_code;
   result_t    scan_res;

   always_comb begin
      // NOTE: every signal driven here gets a default first so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      sample      = (scan_cnt_q == SCAN_LAST);
      scan_end    = sample && (col_idx_q == 2'd3);
      scan_cnt_d  = sample ? '0 : scan_cnt_q + CNT_W'(1);
      col_idx_d   = sample ? col_idx_q + 2'd1 : col_idx_q;
      // Column drive comes straight from a flop so the pins never glitch.
      col_d       = ~(4'b0001 << col_idx_d);

      col_hits = '0;
      col_code = '0;
      for (int r = 0; r < 4; r++) begin
         if (!row_s2_q[r]) begin
            col_hits = col_hits + 3'd1;
            col_code = decode_key(r[1:0], col_idx_q);
         end
      end

      // Fold this column into the per-scan tally; anything beyond one hit is
      // only ever reported as MULTI, so the tally saturates at 2.
      hit_sum     = {1'b0, acc_hits_q} + col_hits;
      merged_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      merged_code = (acc_hits_q != 2'd0) ? acc_code_q : col_code;

      acc_hits_d = acc_hits_q;
      acc_code_d = acc_code_q;
      if (sample) begin
         if (scan_end) begin
            acc_hits_d = '0;
            acc_code_d = '0;
         end else begin
            acc_hits_d = merged_hits;
            acc_code_d = merged_code;
         end
      end

      case (merged_hits)
         2'd0:    scan_res = RES_NONE;
         2'd1:    scan_res = RES_KEY;
         default: scan_res = RES_MULTI;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Debounce FSM: acts only on complete scan results
   // ---------------------------------------------------------------------------
   logic accept;

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      dcnt_d  = dcnt_q;
      accept  = 1'b0;

      if (scan_end) begin
         case (state_q)
            ST_IDLE: begin
               if (scan_res == RES_KEY) begin
                  state_d = ST_PRESS;
                  cand_d  = merged_code;
                  dcnt_d  = DCNT_ONE;
               end
            end
            ST_PRESS: begin
               if (scan_res == RES_KEY && merged_code == cand_q) begin
                  if (dcnt_q == DCNT_LAST) begin
                     state_d = ST_HELD;
                     accept  = 1'b1;
                  end else begin
                     dcnt_d = dcnt_q + DCNT_ONE;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_HELD: begin
               // No auto-repeat: a held key (or a held chord) parks here.
               if (scan_res == RES_NONE) begin
                  state_d = ST_RELEASE;
                  dcnt_d  = DCNT_ONE;
               end
            end
            default: begin // ST_RELEASE
               if (scan_res == RES_NONE) begin
                  if (dcnt_q == DCNT_LAST) begin
                     state_d = ST_IDLE;
                  end else begin
                     dcnt_d = dcnt_q + DCNT_ONE;
                  end
               end else begin
                  state_d = ST_HELD;
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Digit storage
   // ---------------------------------------------------------------------------
   always_comb begin
      key_valid_d = accept;
      key_code_d  = accept ? cand_q : key_code_q;
      count_d     = count_q;
      digit_d     = digit_q;

      // resetCount wins over a same-cycle accept: that digit is dropped, but
      // key_valid/key_code above still report the press.
      if (resetCount) begin
         count_d = '0;
         digit_d = '0;
      end else if (accept && count_q < 4'd8) begin
         digit_d[count_q[2:0]] = cand_q;
         count_d               = count_q + 4'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state is updated only with non-blocking
         // assignments so every flop samples the pre-edge values.
         row_s1_q    <= 4'hF;
         row_s2_q    <= 4'hF;
         scan_cnt_q  <= '0;
         col_idx_q   <= '0;
         col_q       <= 4'b1110;
         acc_hits_q  <= '0;
         acc_code_q  <= '0;
         state_q     <= ST_IDLE;
         cand_q      <= '0;
         dcnt_q      <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         count_q     <= '0;
         // NOTE: the digit bank is visible to the unlocker straight out of
         // reset, so it is reset like ordinary flops rather than left as an
         // uninitialised RAM.
         digit_q     <= '0;
      end else begin
         row_s1_q    <= row;
         row_s2_q    <= row_s1_q;
         scan_cnt_q  <= scan_cnt_d;
         col_idx_q   <= col_idx_d;
         col_q       <= col_d;
         acc_hits_q  <= acc_hits_d;
         acc_code_q  <= acc_code_d;
         state_q     <= state_d;
         cand_q      <= cand_d;
         dcnt_q      <= dcnt_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         count_q     <= count_d;
         digit_q     <= digit_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign col            = col_q;
   assign key_valid      = key_valid_q;
   assign key_code       = key_code_q;
   assign inputCount     = count_q;
   assign userNameInput0 = digit_q[0];
   assign userNameInput1 = digit_q[1];
   assign userNameInput2 = digit_q[2];
   assign userNameInput3 = digit_q[3];
   assign passwordInput0 = digit_q[4];
   assign passwordInput1 = digit_q[5];
   assign passwordInput2 = digit_q[6];
   assign passwordInput3 = digit_q[7];

endmodule

// File: tb/tb_keypad_entry.sv
// -----------------------------------------------------------------------------
// tb_keypad_entry
//
// Bench for keypad_entry with SCAN_DIV=4 and DEBOUNCE_SCANS=2 (one scan is
// 16 cycles). A keypad model pulls rows low for pressed keys in the driven
// column. Each press that should be accepted pushes its code and resulting
// inputCount into a queue; a monitor pops and compares on every key_valid.
// -----------------------------------------------------------------------------
module tb_keypad_entry;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 2;
   localparam int SCAN_CYC = 4 * SCAN_DIV;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row;
   logic [3:0] col;
   logic       resetCount = 1'b0;
   logic [3:0] u0, u1, u2, u3, p0, p1, p2, p3;
   logic [3:0] inputCount;
   logic       key_valid;
   logic [3:0] key_code;

   logic [15:0] pressed = '0;   // bit r*4+c

   keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
      .clk            (clk),
      .rst            (rst),
      .row            (row),
      .col            (col),
      .resetCount     (resetCount),
      .userNameInput0 (u0),
      .userNameInput1 (u1),
      .userNameInput2 (u2),
      .userNameInput3 (u3),
      .passwordInput0 (p0),
      .passwordInput1 (p1),
      .passwordInput2 (p2),
      .passwordInput3 (p3),
      .inputCount     (inputCount),
      .key_valid      (key_valid),
      .key_code       (key_code)
   );

   always #5 clk = ~clk;

   // Keypad matrix model
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   logic [3:0] dut_digit [8];
   assign dut_digit[0] = u0;
   assign dut_digit[1] = u1;
   assign dut_digit[2] = u2;
   assign dut_digit[3] = u3;
   assign dut_digit[4] = p0;
   assign dut_digit[5] = p1;
   assign dut_digit[6] = p2;
   assign dut_digit[7] = p3;

   // Key legend by index r*4+c
   logic [3:0] key_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'h0, 4'hF, 4'hE, 4'hD};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard
   typedef struct packed {
      logic [3:0] code;
      logic [3:0] count;
   } exp_t;

   exp_t       sb_q [$];
   exp_t       mon_e;
   logic [3:0] exp_digit [8];
   int         exp_count;

   always @(negedge clk) begin
      if (rst === 1'b0 && key_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_key_valid: got key_code %0h, expected no accept (t=%0t)",
                     key_code, $time);
         end else begin
            mon_e = sb_q.pop_front();
            check("key_code", {28'd0, key_code}, {28'd0, mon_e.code});
            check("count_at_accept", {28'd0, inputCount}, {28'd0, mon_e.count});
         end
      end
   end

   task automatic model_clear();
      exp_count = 0;
      for (int i = 0; i < 8; i++) exp_digit[i] = 4'h0;
   endtask

   task automatic expect_accept(input int idx, input logic rc);
      exp_t e;
      if (rc) begin
         model_clear();
      end else if (exp_count < 8) begin
         exp_digit[exp_count] = key_tab[idx];
         exp_count++;
      end
      e.code  = key_tab[idx];
      e.count = 4'(exp_count);
      sb_q.push_back(e);
   endtask

   task automatic check_store(input string tag);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_digit%0d", tag, i), {28'd0, dut_digit[i]}, {28'd0, exp_digit[i]});
      check($sformatf("%s_count", tag), {28'd0, inputCount}, 32'(exp_count));
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Align to the first cycle of a fresh scan (column 0 just driven)
   task automatic sync_scan();
      logic [3:0] prev;
      bit         found;
      prev  = col;
      found = 1'b0;
      for (int i = 0; i < 3 * SCAN_CYC && !found; i++) begin
         @(posedge clk);
         #1;
         if (col == 4'b1110 && prev == 4'b0111) found = 1'b1;
         prev = col;
      end
      if (!found) begin
         n_checks++;
         n_fail++;
         $display("FAIL scan_sync_timeout: got col %b, expected rotation back to 1110", col);
      end
   endtask

   task automatic press(input int idx, input int nscans, input bit acc);
      sync_scan();
      pressed = 16'd1 << idx;
      if (acc) expect_accept(idx, resetCount);
      wait_cyc(nscans * SCAN_CYC);
      pressed = '0;
      wait_cyc((DEB + 1) * SCAN_CYC);
   endtask

   task automatic pulse_reset_count();
      resetCount = 1'b1;
      wait_cyc(1);
      resetCount = 1'b0;
      model_clear();
      wait_cyc(1);
   endtask

   // Watchdog
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   logic [3:0] exp_col;
   int         drain;

   initial begin
      model_clear();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);

      // 1. Reset state and column rotation
      check("rst_col", {28'd0, col}, 32'h0000_000E);
      check("rst_key_valid", {31'd0, key_valid}, 32'd0);
      check("rst_key_code", {28'd0, key_code}, 32'd0);
      check_store("rst");
      rst = 1'b0;
      for (int i = 0; i < SCAN_CYC; i++) begin
         exp_col = ~(4'b0001 << (i / SCAN_DIV));
         check("col_rotate", {28'd0, col}, {28'd0, exp_col});
         @(negedge clk);
      end
      check_store("after_release");

      // 2. Single key "6" held 3 scans
      press(6, 3, 1'b1);
      check("t2_user0", {28'd0, u0}, 32'h6);
      check("t2_count", {28'd0, inputCount}, 32'd1);
      check("t2_key_code_held", {28'd0, key_code}, 32'h6);
      pulse_reset_count();
      check_store("t2_clear");

      // 3. Fill username and password, then one extra key
      for (int k = 0; k < 9; k++) press(k, 2, 1'b1);
      check("t3_user0", {28'd0, u0}, 32'h1);
      check("t3_user1", {28'd0, u1}, 32'h2);
      check("t3_user2", {28'd0, u2}, 32'h3);
      check("t3_user3", {28'd0, u3}, 32'hA);
      check("t3_pass0", {28'd0, p0}, 32'h4);
      check("t3_pass1", {28'd0, p1}, 32'h5);
      check("t3_pass2", {28'd0, p2}, 32'h6);
      check("t3_pass3", {28'd0, p3}, 32'hB);
      check("t3_count_sat", {28'd0, inputCount}, 32'd8);
      check("t3_last_code", {28'd0, key_code}, 32'h7);

      // 6a. resetCount with five digits stored
      pulse_reset_count();
      press(12, 2, 1'b1);
      press(13, 2, 1'b1);
      press(14, 2, 1'b1);
      press(15, 2, 1'b1);
      press(9, 2, 1'b1);
      check("t6_count5", {28'd0, inputCount}, 32'd5);
      check("t6_pass0", {28'd0, p0}, 32'h8);
      pulse_reset_count();
      check("t6_cleared_count", {28'd0, inputCount}, 32'd0);
      check_store("t6_clear");

      // 4. Bounce of one scan, then a one-scan release glitch while held
      press(5, 1, 1'b0);
      check("t4_bounce_count", {28'd0, inputCount}, 32'd0);
      sync_scan();
      pressed = 16'd1 << 10;
      expect_accept(10, 1'b0);
      wait_cyc(3 * SCAN_CYC);
      pressed = '0;
      wait_cyc(SCAN_CYC);
      pressed = 16'd1 << 10;
      wait_cyc(2 * SCAN_CYC);
      pressed = '0;
      wait_cyc((DEB + 1) * SCAN_CYC);
      check("t4_glitch_count", {28'd0, inputCount}, 32'd1);
      check("t4_user0", {28'd0, u0}, 32'h9);

      // 5. Two keys together, then a single key
      sync_scan();
      pressed = 16'b0000_0000_0000_0011;
      wait_cyc(3 * SCAN_CYC);
      pressed = '0;
      wait_cyc((DEB + 1) * SCAN_CYC);
      check("t5_multi_count", {28'd0, inputCount}, 32'd1);
      press(11, 2, 1'b1);
      check("t5_user1", {28'd0, u1}, 32'hC);
      check_store("t5");

      // 6b. Accept while resetCount is high
      resetCount = 1'b1;
      press(3, 2, 1'b1);
      resetCount = 1'b0;
      wait_cyc(1);
      check("t6b_count", {28'd0, inputCount}, 32'd0);
      check("t6b_key_code", {28'd0, key_code}, 32'hA);
      check_store("t6b");

      // 6c. rst while in PRESS, key held through reset
      press(4, 2, 1'b1);
      check("t6c_pre_count", {28'd0, inputCount}, 32'd1);
      sync_scan();
      pressed = 16'd1 << 13;
      wait_cyc(SCAN_CYC + 2);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6c_rst_col", {28'd0, col}, 32'h0000_000E);
      check("t6c_rst_count", {28'd0, inputCount}, 32'd0);
      check("t6c_rst_key_valid", {31'd0, key_valid}, 32'd0);
      model_clear();
      check_store("t6c_rst");
      wait_cyc(3);
      expect_accept(13, 1'b0);
      rst = 1'b0;
      wait_cyc(4 * SCAN_CYC);
      pressed = '0;
      wait_cyc((DEB + 1) * SCAN_CYC);
      check("t6c_user0", {28'd0, u0}, 32'hF);
      check_store("t6c_final");

      // Every expected accept must have been seen
      drain = 0;
      while (sb_q.size() != 0 && drain < 8 * SCAN_CYC) begin
         @(posedge clk);
         drain++;
      end
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_accepts: got %0d outstanding, expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
